// File: rtl/mux_wd_pkg.sv
// Shared constants and types for the register-file write-data selector (mux_wd).
// Selector codes at or above WD_SEL_ILLEGAL_MIN are illegal and select zero.
package mux_wd_pkg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 3;

  localparam logic [2:0] WD_SEL_0           = 3'd0;
  localparam logic [2:0] WD_SEL_1           = 3'd1;
  localparam logic [2:0] WD_SEL_2           = 3'd2;
  localparam logic [2:0] WD_SEL_3           = 3'd3;
  localparam logic [2:0] WD_SEL_4           = 3'd4;
  localparam logic [2:0] WD_SEL_5           = 3'd5;
  localparam logic [2:0] WD_SEL_ILLEGAL_MIN = 3'd6;

  typedef logic [31:0] wd_word_t;

endpackage : mux_wd_pkg

// File: rtl/mux_wd_core.sv
// Pure combinational 6:1 write-data select with a zero default and an
// illegal-code indication for selector values at or above N_IN.
module mux_wd_core #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3,
  parameter int N_IN   = 6
) (
  input  logic [SEL_W-1:0]  selector_i,
  input  logic [DATA_W-1:0] data_0_i,
  input  logic [DATA_W-1:0] data_1_i,
  input  logic [DATA_W-1:0] data_2_i,
  input  logic [DATA_W-1:0] data_3_i,
  input  logic [DATA_W-1:0] data_4_i,
  input  logic [DATA_W-1:0] data_5_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sel_illegal_o
);
  import mux_wd_pkg::*;

  // Unknown selector bits fall into the default arm, which drives zero.
  always_comb begin
    data_o        = {DATA_W{1'b0}};
    sel_illegal_o = 1'b0;
    case (selector_i)
      WD_SEL_0: data_o = data_0_i;
      WD_SEL_1: data_o = data_1_i;
      WD_SEL_2: data_o = data_2_i;
      WD_SEL_3: data_o = data_3_i;
      WD_SEL_4: data_o = data_4_i;
      WD_SEL_5: data_o = data_5_i;
      default: begin
        data_o        = {DATA_W{1'b0}};
        sel_illegal_o = (int'(selector_i) >= N_IN);
      end
    endcase
  end

endmodule : mux_wd_core

// File: rtl/mux_wd.sv
// Register-file write-data selector: mux_wd_core plus a sticky illegal-select flag.
// Optional feature macro MUX_WD_REG_OUT_EN registers data_out (1-cycle latency).
module mux_wd #(
  parameter int DATA_W = mux_wd_pkg::DATA_W,
  parameter int SEL_W  = mux_wd_pkg::SEL_W,
  parameter int N_IN   = int'(mux_wd_pkg::WD_SEL_ILLEGAL_MIN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  selector,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  input  logic [DATA_W-1:0] data_4,
  input  logic [DATA_W-1:0] data_5,
  output logic [DATA_W-1:0] data_out,
  output logic              sel_err
);
  import mux_wd_pkg::*;

  logic [DATA_W-1:0] core_data_s;
  logic              sel_illegal_s;
  logic              sel_err_q;
  logic              sel_err_d;

  mux_wd_core #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W),
    .N_IN   (N_IN)
  ) u_core (
    .selector_i    (selector),
    .data_0_i      (data_0),
    .data_1_i      (data_1),
    .data_2_i      (data_2),
    .data_3_i      (data_3),
    .data_4_i      (data_4),
    .data_5_i      (data_5),
    .data_o        (core_data_s),
    .sel_illegal_o (sel_illegal_s)
  );

  // Sticky: once set, only rst_n clears it.
  always_comb begin
    sel_err_d = sel_err_q | sel_illegal_s;
  end

  // Illegal-select flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

`ifdef MUX_WD_REG_OUT_EN
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] data_out_d;

  always_comb begin
    data_out_d = core_data_s;
  end

  // Output register; resets to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= {DATA_W{1'b0}};
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
`else
  assign data_out = core_data_s;
`endif

endmodule : mux_wd

// File: tb/tb_mux_wd.sv
// Directed self-checking bench for mux_wd; data_k is tied to k unless overridden.
// Expectations adapt when MUX_WD_REG_OUT_EN is defined (registered data_out).
module tb_mux_wd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  selector;
  logic [31:0] data_0, data_1, data_2, data_3, data_4, data_5;
  logic [31:0] data_out;
  logic        sel_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_wd dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .selector (selector),
    .data_0   (data_0),
    .data_1   (data_1),
    .data_2   (data_2),
    .data_3   (data_3),
    .data_4   (data_4),
    .data_5   (data_5),
    .data_out (data_out),
    .sel_err  (sel_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic exp);
    check(tag, {31'd0, sel_err}, {31'd0, exp});
  endtask

  // Wait until a data_out change driven at a negedge is visible.
  task automatic settle();
`ifdef MUX_WD_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic drive_sel(input logic [2:0] s);
    @(negedge clk);
    selector = s;
    settle();
  endtask

  initial begin
    data_0 = 32'd0; data_1 = 32'd1; data_2 = 32'd2;
    data_3 = 32'd3; data_4 = 32'd4; data_5 = 32'd5;
    selector = 3'd3;
    rst_n = 1'b0;

    // Reset state.
    #1;
    check_err("rst_sel_err", 1'b0);
`ifdef MUX_WD_REG_OUT_EN
    check("rst_dout_zero", data_out, 32'd0);
    @(posedge clk); #1;
    check("rst_dout_held", data_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_dout_no_edge", data_out, 32'd0);
    @(posedge clk); #1;
    check("rel_dout_first_edge", data_out, 32'd3);
    @(negedge clk);
    selector = 3'd1;
    #1;
    check("lat_dout_old", data_out, 32'd3);
    @(posedge clk); #1;
    check("lat_dout_new", data_out, 32'd1);
`else
    check("rst_dout_transparent", data_out, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Legal codes 0..5.
    for (int k = 0; k < 6; k++) begin
      drive_sel(3'(k));
      check($sformatf("sel_%0d", k), data_out, 32'(k));
      @(posedge clk); #1;
      check_err($sformatf("sel_%0d_err", k), 1'b0);
    end

    // Illegal codes 6 and 7, then back to 2.
    @(negedge clk);
    selector = 3'd6;
    #1;
    check_err("ill6_err_before_edge", 1'b0);
`ifndef MUX_WD_REG_OUT_EN
    check("ill6_dout_comb", data_out, 32'd0);
`endif
    @(posedge clk); #1;
    check_err("ill6_err_after_edge", 1'b1);
    check("ill6_dout", data_out, 32'd0);
    drive_sel(3'd7);
    check("ill7_dout", data_out, 32'd0);
    drive_sel(3'd2);
    check("back2_dout", data_out, 32'd2);
    @(posedge clk); #1;
    check_err("back2_err_sticky", 1'b1);

    // Asynchronous reset pulse between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_err("async_rst_err", 1'b0);
`ifdef MUX_WD_REG_OUT_EN
    check("async_rst_dout", data_out, 32'd0);
`endif
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_err("post_rst_err", 1'b0);

    // Illegal code for exactly one cycle.
    @(negedge clk);
    selector = 3'd7;
    @(posedge clk); #1;
    check_err("one_cyc7_err", 1'b1);
    check("one_cyc7_dout", data_out, 32'd0);
    drive_sel(3'd4);
    check("sel4_dout", data_out, 32'd4);

    // Data change on the selected input, then switch source.
    @(negedge clk);
    data_4 = 32'hDEADBEEF;
    settle();
    check("data4_follow", data_out, 32'hDEADBEEF);
    drive_sel(3'd5);
    check("sel5_dout", data_out, 32'd5);

    // Illegal code present across reset and its release.
    @(negedge clk);
    rst_n = 1'b0;
    selector = 3'd6;
    @(posedge clk); #1;
    check_err("rst_hold_ill_err", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_err("rel_ill_no_edge", 1'b0);
    @(posedge clk); #1;
    check_err("rel_ill_first_edge", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mux_wd
